full_subtractor_reg: RTL and testbench
======================================

Name: full_subtractor_reg

Overview:
- Registered full subtractor: computes a − b − c (c = borrow-in) per bit lane, producing difference and borrow-out.
- Ripple chain of 1-bit full-subtractor cells, WIDTH bits wide, followed by one output register stage with a valid flag.
- Default WIDTH=1 is the classic single-bit full subtractor.
- Used as a building block for multi-bit subtract datapaths and as a borrow-chain slice.

Parameters:
- WIDTH, 1, operand width in bits (≥1); lanes ripple LSB→MSB.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b, c this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c  input  1  borrow-in to bit 0.
- out_valid  output  1  difference/borrow hold a fresh result.
- difference  output  WIDTH  registered (a − b − c) mod 2^WIDTH.
- borrow  output  1  registered borrow-out of MSB cell; 1 when a < b + c (unsigned).

Behaviour:
- Cell i (inputs ai, bi, bin_i):
  - d_i = ai ^ bi ^ bin_i
  - bout_i = (~ai & bi) | (~ai & bin_i) | (bi & bin_i)
  - bin_0 = c; bin_(i+1) = bout_i; borrow = bout_(WIDTH−1).
- 1-bit truth table (a,b,c → difference,borrow):
  - 000→0,0; 001→1,1; 010→1,1; 011→0,1
  - 100→1,0; 101→0,0; 110→0,0; 111→1,1
- Latency: exactly 1 cycle. At the rising edge with in_valid=1, difference and borrow load the combinational result and out_valid←1.
- At a rising edge with in_valid=0: out_valid←0; difference/borrow hold their previous values. No spurious updates.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no ready signal.
- Repeated identical inputs produce identical outputs each cycle; no internal state besides the output register.
- Reset (async, asserted any time, including mid-stream):
  - difference=0, borrow=0, out_valid=0 immediately, without waiting for a clock edge.
  - While rst=1, inputs are ignored.
  - First capture after deassertion is at the first rising edge with rst=0 and in_valid=1.
- Arithmetic: unsigned. Wrap-around is modulo 2^WIDTH, with borrow=1 signalling underflow.
  - Boundary: a=0, b=all-ones, c=1 → difference=0, borrow=1.
  - Boundary: a=b, c=0 → difference=0, borrow=0.
- No X-propagation tolerance is required. Inputs must be known when in_valid=1.

Test Plan:
- WIDTH=1, reset then apply a,b,c = 000, 010, 101, 111 each with in_valid=1 for one cycle → one cycle later, difference,borrow = 0,0 / 1,1 / 0,0 / 1,1 with out_valid=1.
- WIDTH=1, exhaustive 8 combinations back-to-back → outputs match the truth table above, each delayed by exactly 1 cycle. out_valid stays 1 throughout.
- WIDTH=1, apply a=1,b=1,c=1 then in_valid=0 for 3 cycles → difference=1, borrow=1 held; out_valid=0 after the first idle edge.
- Assert rst asynchronously between clock edges while out_valid=1 and difference=1 → difference=0, borrow=0, out_valid=0 before the next edge. Inputs during reset are ignored.
- WIDTH=8: a=0x00, b=0xFF, c=1 → difference=0x00, borrow=1. Then a=0x35, b=0x12, c=0 → 0x23, borrow=0. Then a=0x10, b=0x10, c=1 → 0xFF, borrow=1.
- WIDTH=4, random a/b/c with random in_valid for 1000 cycles vs reference model {borrow,difference} = (a − b − c) mod 2^(WIDTH+1) → no mismatches.

Source files
------------

// File: rtl/full_subtractor_reg_if.sv
// Operand/result bundle for the registered full subtractor.
// The master drives operands and the slave returns the registered result.
interface full_subtractor_reg_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             out_valid;
  logic [WIDTH-1:0] difference;
  logic             borrow;

  modport master (
    output in_valid, a, b, c,
    input  out_valid, difference, borrow
  );

  modport slave (
    input  in_valid, a, b, c,
    output out_valid, difference, borrow
  );
endinterface

// File: rtl/full_subtractor_reg.sv
// Ripple-borrow subtractor computing a - b - c across WIDTH 1-bit cells.
// The result passes through a single output register stage that carries a valid flag.
module full_subtractor_reg #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  full_subtractor_reg_if.slave  bus
);

  logic [WIDTH:0]   bin_chain;
  logic [WIDTH-1:0] diff_comb;

  logic             out_valid_reg;
  logic [WIDTH-1:0] difference_reg;
  logic             borrow_reg;

  assign bin_chain[0] = bus.c;

  // Each cell passes its borrow-out to the next more significant cell as that cell's borrow-in.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign diff_comb[gi]     = bus.a[gi] ^ bus.b[gi] ^ bin_chain[gi];
      assign bin_chain[gi + 1] = (~bus.a[gi] & bus.b[gi])
                               | (~bus.a[gi] & bin_chain[gi])
                               | (bus.b[gi] & bin_chain[gi]);
    end
  endgenerate

  // The result registers update only on valid input, so idle cycles hold the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      difference_reg <= '0;
      borrow_reg     <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        difference_reg <= diff_comb;
        borrow_reg     <= bin_chain[WIDTH];
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.difference = difference_reg;
  assign bus.borrow     = borrow_reg;

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Bench for full_subtractor_reg at WIDTH 1, 8 and 4.
// An arithmetic reference model is compared on every falling edge, alongside literal spot checks.
module tb_full_subtractor_reg;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  full_subtractor_reg_if #(.WIDTH(1)) bus1 ();
  full_subtractor_reg_if #(.WIDTH(8)) bus8 ();
  full_subtractor_reg_if #(.WIDTH(4)) bus4 ();

  full_subtractor_reg #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(bus1));
  full_subtractor_reg #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(bus8));
  full_subtractor_reg #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model's top bit is the borrow and its low bits are the difference.
  function automatic int sub_model(int a, int b, int c, int w);
    return (a - b - c) & ((1 << (w + 1)) - 1);
  endfunction

  logic       m1_v = 1'b0;
  logic [1:0] m1_bd = '0;
  logic       m8_v = 1'b0;
  logic [8:0] m8_bd = '0;
  logic       m4_v = 1'b0;
  logic [4:0] m4_bd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_v <= 1'b0; m1_bd <= '0;
      m8_v <= 1'b0; m8_bd <= '0;
      m4_v <= 1'b0; m4_bd <= '0;
    end else begin
      m1_v <= bus1.in_valid;
      m8_v <= bus8.in_valid;
      m4_v <= bus4.in_valid;
      if (bus1.in_valid) m1_bd <= 2'(sub_model(int'(bus1.a), int'(bus1.b), int'(bus1.c), 1));
      if (bus8.in_valid) m8_bd <= 9'(sub_model(int'(bus8.a), int'(bus8.b), int'(bus8.c), 8));
      if (bus4.in_valid) m4_bd <= 5'(sub_model(int'(bus4.a), int'(bus4.b), int'(bus4.c), 4));
    end
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got {valid,borrow,diff}=%h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_w1", 10'({bus1.out_valid, bus1.borrow, bus1.difference}), 10'({m1_v, m1_bd}));
    chk("model_w8", 10'({bus8.out_valid, bus8.borrow, bus8.difference}), 10'({m8_v, m8_bd}));
    chk("model_w4", 10'({bus4.out_valid, bus4.borrow, bus4.difference}), 10'({m4_v, m4_bd}));
  end

  function automatic logic [9:0] pack1();
    return 10'({bus1.out_valid, bus1.borrow, bus1.difference});
  endfunction

  logic [2:0] dir_vec [4] = '{3'b000, 3'b010, 3'b101, 3'b111};
  logic [1:0] dir_exp [4] = '{2'b00, 2'b11, 2'b00, 2'b11};
  logic [1:0] tt_exp  [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
  logic [24:0] w8_vec [3] = '{{8'h00, 8'hFF, 1'b1}, {8'h35, 8'h12, 1'b0}, {8'h10, 8'h10, 1'b1}};
  logic [9:0]  w8_exp [3] = '{{1'b1, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h23}, {1'b1, 1'b1, 8'hFF}};

  initial begin
    rst = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_w1", pack1(), 10'h000);
    chk("reset_w8", 10'({bus8.out_valid, bus8.borrow, bus8.difference}), 10'h000);
    rst = 1'b0;

    // Four directed single-bit vectors, back-to-back.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      {bus1.a, bus1.b, bus1.c} = dir_vec[i];
      @(posedge clk); #1;
      chk($sformatf("dir_w1_%0d", i), pack1(), {8'b1, dir_exp[i]});
    end

    // Exhaustive truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      {bus1.a, bus1.b, bus1.c} = 3'(i);
      @(posedge clk); #1;
      chk($sformatf("tt_w1_%0d", i), pack1(), {8'b1, tt_exp[i]});
    end

    // Hold after 111 across three idle edges.
    @(negedge clk);
    {bus1.a, bus1.b, bus1.c} = 3'b111;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    {bus1.a, bus1.b, bus1.c} = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_w1_%0d", i), pack1(), 10'b00_0000_0011);
    end

    // Asynchronous reset between edges while a result is visible.
    @(negedge clk);
    {bus1.a, bus1.b, bus1.c} = 3'b111;
    bus1.in_valid = 1'b1;
    @(posedge clk); #3;
    chk("pre_rst_w1", pack1(), 10'b00_0000_0111);
    rst = 1'b1;
    {bus1.a, bus1.b, bus1.c} = 3'b010;
    #1;
    chk("async_rst_w1", pack1(), 10'h000);
    @(posedge clk); #1;
    chk("rst_ignore_w1", pack1(), 10'h000);
    @(negedge clk);
    rst = 1'b0;
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_w1", pack1(), 10'h000);
    @(negedge clk);
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("first_capture_w1", pack1(), 10'b00_0000_0111);
    @(negedge clk);
    bus1.in_valid = 1'b0;

    // WIDTH=8 boundaries.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1;
      {bus8.a, bus8.b, bus8.c} = w8_vec[i];
      @(posedge clk); #1;
      chk($sformatf("w8_%0d", i), 10'({bus8.out_valid, bus8.borrow, bus8.difference}), w8_exp[i]);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;

    // WIDTH=4 randomized run; checking happens in the per-cycle compare.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus4.in_valid = 1'($urandom_range(0, 1));
      bus4.a = 4'($urandom);
      bus4.b = 4'($urandom);
      bus4.c = 1'($urandom);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
